// File: rtl/serial_addsub_n_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM state
// encodings, operation codes and the single-bit full-adder helper.
package serial_addsub_n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // One full-adder cell; returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        full_add = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
    endfunction

endpackage

// File: rtl/serial_addsub_n_digit_adder.sv
// Combinational DIGIT-bit ripple adder. Besides the carry-out it exposes the
// carry into the top bit so the caller can derive signed overflow.
module digit_adder
    import serial_addsub_n_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic       carry_s;
    logic [1:0] fa_s;

    // Ripple the carry through DIGIT full-adder cells, remembering the carry
    // that enters the most significant cell.
    always_comb begin
        carry_s = ci;
        fa_s    = 2'b00;
        s       = '0;
        c_msb   = ci;
        for (int i = 0; i < DIGIT; i++) begin
            c_msb   = carry_s;
            fa_s    = full_add(x[i], y[i], carry_s);
            s[i]    = fa_s[0];
            carry_s = fa_s[1];
        end
        co = carry_s;
    end

endmodule

// File: rtl/serial_addsub_n.sv
// Digit-serial adder/subtractor. Operands arrive over a valid/ready handshake,
// are consumed DIGIT bits per clock LSB first, and the result (sum, carry-out,
// signed overflow) is offered over a second valid/ready handshake.
module serial_addsub_n
    import serial_addsub_n_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int DIGIT_SAFE = (DIGIT < 1) ? 1 : DIGIT;
    localparam int STEPS      = WIDTH / DIGIT_SAFE;
    localparam int CNT_W      = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    // A digit that does not tile the operand exactly has no meaningful schedule.
    if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT_SAFE) != 0)) begin : g_param_check
        $error("serial_addsub_n: WIDTH must be >= 1 and a multiple of DIGIT");
    end

    state_e           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             out_valid_r;
    logic             busy_r;

    logic [DIGIT-1:0] dsum_s;
    logic             dco_s;
    logic             dmsb_s;
    logic [WIDTH-1:0] acc_next_s;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x     (a_r[DIGIT-1:0]),
        .y     (b_r[DIGIT-1:0]),
        .ci    (carry_r),
        .s     (dsum_s),
        .co    (dco_s),
        .c_msb (dmsb_s)
    );

    // Result assembly: each new digit enters at the top and earlier digits
    // move down, so after the last step the word is in natural order.
    if (DIGIT < WIDTH) begin : g_acc
        logic [WIDTH-DIGIT-1:0] acc_r;

        assign acc_next_s = {dsum_s, acc_r};

        // Partial-result shift register, advanced only while running.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_r <= '0;
            end else if (state_r == ST_RUN) begin
                acc_r <= acc_next_s[WIDTH-1:DIGIT];
            end else begin
                acc_r <= acc_r;
            end
        end
    end else begin : g_single
        assign acc_next_s = dsum_s;
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

    // Control FSM with operand shift registers, step counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            a_r         <= '0;
            b_r         <= '0;
            carry_r     <= 1'b0;
            cnt_r       <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1; the incoming cin is ignored then.
                        a_r     <= a;
                        b_r     <= (op == OP_SUB) ? ~b : b;
                        carry_r <= (op == OP_ADD) ? cin : 1'b1;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_r     <= a_r >> DIGIT;
                    b_r     <= b_r >> DIGIT;
                    carry_r <= dco_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_CNT) begin
                        sum_r       <= acc_next_s;
                        cout_r      <= dco_s;
                        ovf_r       <= dmsb_s ^ dco_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub_n.sv
// Bench for serial_addsub_n: a bit-serial (DIGIT=1) and a nibble-serial
// (DIGIT=4) instance, both 8 bits wide, driven from a vector table, directed
// corner-case sequences and random operands checked against an arithmetic model.
module tb_serial_addsub_n;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] in_valid;
    logic [1:0] in_ready;
    logic [1:0] out_valid;
    logic [1:0] out_ready;
    logic [1:0] cout;
    logic [1:0] ovf;
    logic [1:0] busy;
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
    logic       cin;
    logic [7:0] sum_v [2];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       op;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    serial_addsub_n #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .sum(sum_v[0]), .cout(cout[0]), .ovf(ovf[0]),
        .busy(busy[0])
    );

    serial_addsub_n #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .sum(sum_v[1]), .cout(cout[1]), .ovf(ovf[1]),
        .busy(busy[1])
    );

    // Arithmetic reference: {ovf, cout, sum} from unsigned and signed integer math.
    function automatic logic [9:0] ref_op(input logic [7:0] x, input logic [7:0] y,
                                          input logic o, input logic ci);
        int   ua, ub, sa, sb, c, r_u, r_s;
        logic co, ov;
        ua = int'(x);
        ub = int'(y);
        sa = int'($signed(x));
        sb = int'($signed(y));
        c  = ci ? 1 : 0;
        if (o) begin
            r_u = ua - ub;
            r_s = sa - sb;
            co  = (ua >= ub);
        end else begin
            r_u = ua + ub + c;
            r_s = sa + sb + c;
            co  = (r_u > 255);
        end
        ov = (r_s > 127) || (r_s < -128);
        return {ov, co, r_u[7:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic start_op(input int sel, input logic [7:0] x, input logic [7:0] y,
                            input logic o, input logic ci);
        int w;
        w = 0;
        @(negedge clk);
        while (in_ready[sel] !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_idle", 32'(in_ready[sel]), 32'd1);
        a = x; b = y; op = o; cin = ci;
        in_valid[sel] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[sel] = 1'b0;
        a = 8'($urandom); b = 8'($urandom); op = 1'($urandom); cin = 1'($urandom);
        check("busy_after_accept", 32'(busy[sel]), 32'd1);
    endtask

    task automatic wait_done(input int sel, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (out_valid[sel] !== 1'b1 && lat < 40);
    endtask

    task automatic finish_op(input int sel);
        out_ready[sel] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[sel] = 1'b0;
        @(negedge clk);
        check("out_valid_drop", 32'(out_valid[sel]), 32'd0);
        check("in_ready_after", 32'(in_ready[sel]), 32'd1);
    endtask

    task automatic do_op(input int sel, input logic [7:0] x, input logic [7:0] y,
                         input logic o, input logic ci, input logic [7:0] es,
                         input logic ec, input logic eo, input string name);
        int lat;
        start_op(sel, x, y, o, ci);
        wait_done(sel, lat);
        check($sformatf("%s_latency", name), 32'(lat), (sel == 1) ? 32'd2 : 32'd8);
        check($sformatf("%s_sum", name), 32'(sum_v[sel]), 32'(es));
        check($sformatf("%s_cout", name), 32'(cout[sel]), 32'(ec));
        check($sformatf("%s_ovf", name), 32'(ovf[sel]), 32'(eo));
        finish_op(sel);
    endtask

    // Watchdog so a stuck handshake still ends the run.
    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int         lat;
        logic [9:0] r;
        logic [7:0] x, y;
        logic       o, ci;
        int         sel;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

        rst_n = 1'b0;
        in_valid = 2'b00; out_ready = 2'b00;
        a = 8'h00; b = 8'h00; op = 1'b0; cin = 1'b0;
        #12;
        for (int s = 0; s < 2; s++) begin
            check("rst_out_valid", 32'(out_valid[s]), 32'd0);
            check("rst_busy", 32'(busy[s]), 32'd0);
            check("rst_sum", 32'(sum_v[s]), 32'd0);
            check("rst_cout", 32'(cout[s]), 32'd0);
            check("rst_ovf", 32'(ovf[s]), 32'd0);
            check("rst_in_ready", 32'(in_ready[s]), 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table on both digit widths.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) begin
                do_op(s, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin,
                      vecs[i].sum, vecs[i].cout, vecs[i].ovf, $sformatf("vec%0d_d%0d", i, s));
            end
        end

        // Nibble-serial example with carry-in.
        do_op(1, 8'hAB, 8'h55, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, "nibble_abplus55");

        // Backpressure: result must hold and no new operands may be taken.
        start_op(0, 8'h80, 8'hCD, 1'b0, 1'b0);
        wait_done(0, lat);
        check("bp_latency", 32'(lat), 32'd8);
        in_valid[0] = 1'b1;
        a = 8'hFF; b = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid[0]), 32'd1);
            check("bp_sum", 32'(sum_v[0]), 32'h4D);
            check("bp_in_ready", 32'(in_ready[0]), 32'd0);
        end
        check("bp_cout", 32'(cout[0]), 32'd1);
        check("bp_ovf", 32'(ovf[0]), 32'd1);
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        check("bp_idle_in_ready", 32'(in_ready[0]), 32'd1);
        check("bp_idle_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        check("bp_out_valid_drop", 32'(out_valid[0]), 32'd0);
        check("bp_sum_hold_idle", 32'(sum_v[0]), 32'h4D);

        // Reset pulse in the middle of a run aborts the op.
        start_op(0, 8'h0A, 8'h0B, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("mid_rst_busy", 32'(busy[0]), 32'd0);
        check("mid_rst_sum", 32'(sum_v[0]), 32'd0);
        check("mid_rst_cout", 32'(cout[0]), 32'd0);
        check("mid_rst_ovf", 32'(ovf[0]), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready[0]), 32'd1);
        check("post_rst_out_valid", 32'(out_valid[0]), 32'd0);
        do_op(0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, "post_rst_add");

        // Random operands against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            sel = i % 2;
            x   = 8'($urandom_range(0, 255));
            y   = 8'($urandom_range(0, 255));
            o   = 1'($urandom_range(0, 1));
            ci  = 1'($urandom_range(0, 1));
            r   = ref_op(x, y, o, ci);
            do_op(sel, x, y, o, ci, r[7:0], r[8], r[9], $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
